// File: rtl/controle_cronometro.sv
// Stopwatch run/stop/lap/clear controller: button synchronizers, tenth-of-second
// time base, seconds/tenths counters and display-freeze control for the decoder.
//
// state    | meaning
// ZERADO   | cleared, counters and prescaler at zero, waiting for start
// CONTANDO | counting, display follows live time
// VOLTA    | counting, display frozen at lap value (enable low)
// PARADO   | stopped, counters and prescaler hold, display shows stopped time
module controle_cronometro #(
  parameter int TICKS_POR_DECIMO = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inicia,
  input  logic       btn_zera,
  input  logic       btn_volta,
  output logic [9:0] seg,
  output logic [3:0] dec,
  output logic       enable,
  output logic [1:0] estado,
  output logic       estouro
);

  localparam int PW = (TICKS_POR_DECIMO > 1) ? $clog2(TICKS_POR_DECIMO) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_POR_DECIMO - 1);

  typedef enum logic [1:0] {
    ZERADO   = 2'b00,
    CONTANDO = 2'b01,
    VOLTA    = 2'b10,
    PARADO   = 2'b11
  } estado_t;

  estado_t st;
  logic [PW-1:0] pre;

  // bit order for all button vectors: {volta, zera, inicia}
  logic [2:0] sync1, sync2, prev, ev;
  logic [1:0] aquec;
  logic       tick;

  // Events stay blocked until the synchronizer holds real samples, so a
  // button held through reset release never looks like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      ev    <= '0;
      aquec <= '0;
    end else begin
      sync1 <= {btn_volta, btn_zera, btn_inicia};
      sync2 <= sync1;
      prev  <= sync2;
      ev    <= (aquec == 2'd3) ? (sync2 & ~prev) : 3'b000;
      if (aquec != 2'd3) aquec <= aquec + 2'd1;
    end
  end

  assign tick = (pre == PRE_MAX) && ((st == CONTANDO) || (st == VOLTA));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ZERADO;
      pre     <= '0;
      seg     <= '0;
      dec     <= '0;
      enable  <= 1'b1;
      estouro <= 1'b0;
    end else begin
      estouro <= 1'b0;

      if ((st == CONTANDO) || (st == VOLTA))
        pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;

      if (tick) begin
        if (dec == 4'd9) begin
          dec <= 4'd0;
          if (seg == 10'd999) begin
            seg     <= 10'd0;
            estouro <= 1'b1;
          end else begin
            seg <= seg + 10'd1;
          end
        end else begin
          dec <= dec + 4'd1;
        end
      end

      // Inicia is valid in every state, so priority only matters for zera
      // in PARADO and for volta losing to inicia elsewhere.
      case (st)
        ZERADO: begin
          if (ev[0]) begin
            st     <= CONTANDO;
            enable <= 1'b1;
          end
        end
        CONTANDO: begin
          if (ev[0]) begin
            st     <= PARADO;
            enable <= 1'b1;
          end else if (ev[2]) begin
            st     <= VOLTA;
            enable <= 1'b0;
          end
        end
        VOLTA: begin
          if (ev[0]) begin
            st     <= PARADO;
            enable <= 1'b1;
          end else if (ev[2]) begin
            st     <= CONTANDO;
            enable <= 1'b1;
          end
        end
        PARADO: begin
          if (ev[1]) begin
            st     <= ZERADO;
            enable <= 1'b1;
            pre    <= '0;
            seg    <= '0;
            dec    <= '0;
          end else if (ev[0]) begin
            st     <= CONTANDO;
            enable <= 1'b1;
          end
        end
        default: begin
          st     <= ZERADO;
          enable <= 1'b1;
        end
      endcase
    end
  end

  assign estado = st;

endmodule

// File: tb/tb_controle_cronometro.sv
// Scoreboard bench for controle_cronometro: main instance at 4 ticks/tenth,
// a second instance at 1 tick/tenth for the 999.9 -> 000.0 wrap.
module tb_controle_cronometro;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       bi, bz, bv, wi, wz, wv;
  logic [9:0] seg, w_seg;
  logic [3:0] dec, w_dec;
  logic       en, w_en, eso, w_eso;
  logic [1:0] est, w_est;

  controle_cronometro #(.TICKS_POR_DECIMO(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_inicia(bi), .btn_zera(bz), .btn_volta(bv),
    .seg(seg), .dec(dec), .enable(en), .estado(est), .estouro(eso)
  );

  controle_cronometro #(.TICKS_POR_DECIMO(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .btn_inicia(wi), .btn_zera(wz), .btn_volta(wv),
    .seg(w_seg), .dec(w_dec), .enable(w_en), .estado(w_est), .estouro(w_eso)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle press; returns on the negedge right after the state update.
  task automatic press(input logic i, input logic z, input logic v);
    bi = i; bz = z; bv = v;
    step(1);
    bi = 1'b0; bz = 1'b0; bv = 1'b0;
    step(3);
  endtask

  task automatic exp_reset_vals();
    sb_push("rst_seg", 0); sb_push("rst_dec", 0); sb_push("rst_est", 0);
    sb_push("rst_en", 1);  sb_push("rst_eso", 0);
  endtask

  task automatic obs_reset_vals();
    sb_pop(seg); sb_pop(dec); sb_pop(est); sb_pop(en); sb_pop(eso);
  endtask

  initial begin
    rst_n = 1'b0;
    bi = 1'b0; bz = 1'b0; bv = 1'b0;
    wi = 1'b0; wz = 1'b0; wv = 1'b0;
    step(2);
    exp_reset_vals();
    obs_reset_vals();
    rst_n = 1'b1;
    step(3);

    // ZERADO ignores volta and zera
    press(1'b0, 1'b0, 1'b1);
    sb_push("zer_volta_est", 0); sb_pop(est);
    press(1'b0, 1'b1, 1'b0);
    sb_push("zer_zera_est", 0); sb_pop(est);

    // count: 12 ticks = 48 cycles after entry
    press(1'b1, 1'b0, 1'b0);
    sb_push("cnt_entry_est", 1); sb_push("cnt_entry_pre", 0); sb_push("cnt_entry_dec", 0);
    sb_pop(est); sb_pop(dut.pre); sb_pop(dec);
    step(48);
    sb_push("cnt_seg", 1); sb_push("cnt_dec", 2); sb_push("cnt_est", 1);
    sb_pop(seg); sb_pop(dec); sb_pop(est);

    // asynchronous reset mid-count at 12.3
    step(444);
    sb_push("pre_rst_seg", 12); sb_push("pre_rst_dec", 3);
    sb_pop(seg); sb_pop(dec);
    #2 rst_n = 1'b0;
    #1;
    exp_reset_vals();
    obs_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    step(3);

    // lap at 0.5, release at 2.0
    press(1'b1, 1'b0, 1'b0);
    step(16);
    press(1'b0, 1'b0, 1'b1);
    sb_push("lap_est", 2); sb_push("lap_en", 0); sb_push("lap_seg", 0); sb_push("lap_dec", 5);
    sb_pop(est); sb_pop(en); sb_pop(seg); sb_pop(dec);
    step(20);
    sb_push("lap_run_seg", 1); sb_push("lap_run_dec", 0); sb_push("lap_run_en", 0);
    sb_pop(seg); sb_pop(dec); sb_pop(en);
    step(36);
    press(1'b0, 1'b0, 1'b1);
    sb_push("unlap_est", 1); sb_push("unlap_en", 1); sb_push("unlap_seg", 2); sb_push("unlap_dec", 0);
    sb_pop(est); sb_pop(en); sb_pop(seg); sb_pop(dec);

    // stop at pre=2, resume continues the partial tenth
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);
    press(1'b1, 1'b0, 1'b0);
    step(2);
    press(1'b1, 1'b0, 1'b0);
    sb_push("stop_est", 3); sb_push("stop_pre", 2); sb_push("stop_dec", 1);
    sb_pop(est); sb_pop(dut.pre); sb_pop(dec);
    step(10);
    sb_push("hold_pre", 2); sb_push("hold_dec", 1);
    sb_pop(dut.pre); sb_pop(dec);
    press(1'b1, 1'b0, 1'b0);
    sb_push("resume_est", 1); sb_push("resume_pre", 2); sb_push("resume_dec", 1);
    sb_pop(est); sb_pop(dut.pre); sb_pop(dec);
    step(1);
    sb_push("resume1_pre", 3); sb_push("resume1_dec", 1);
    sb_pop(dut.pre); sb_pop(dec);
    step(1);
    sb_push("resume2_dec", 2); sb_push("resume2_pre", 0);
    sb_pop(dec); sb_pop(dut.pre);

    // priority and ignored events
    press(1'b0, 1'b1, 1'b0);
    sb_push("cnt_zera_est", 1); sb_pop(est);
    press(1'b1, 1'b0, 1'b1);
    sb_push("ini_volta_est", 3); sb_push("ini_volta_en", 1);
    sb_pop(est); sb_pop(en);
    press(1'b1, 1'b1, 1'b0);
    sb_push("zera_ini_est", 0); sb_push("zera_ini_seg", 0);
    sb_push("zera_ini_dec", 0); sb_push("zera_ini_pre", 0);
    sb_pop(est); sb_pop(seg); sb_pop(dec); sb_pop(dut.pre);

    // button held through reset release gives no event
    bi = 1'b1;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(6);
    sb_push("held_rst_est", 0); sb_pop(est);
    bi = 1'b0;
    step(4);
    sb_push("held_rel_est", 0); sb_pop(est);

    // wrap 999.9 -> 000.0 at one cycle per tenth
    wi = 1'b1;
    step(1);
    wi = 1'b0;
    step(3);
    sb_push("w_entry_est", 1); sb_push("w_entry_dec", 0);
    sb_pop(w_est); sb_pop(w_dec);
    step(9999);
    sb_push("w_top_seg", 999); sb_push("w_top_dec", 9); sb_push("w_top_eso", 0);
    sb_pop(w_seg); sb_pop(w_dec); sb_pop(w_eso);
    step(1);
    sb_push("w_wrap_seg", 0); sb_push("w_wrap_dec", 0);
    sb_push("w_wrap_eso", 1); sb_push("w_wrap_est", 1);
    sb_pop(w_seg); sb_pop(w_dec); sb_pop(w_eso); sb_pop(w_est);
    step(1);
    sb_push("w_after_eso", 0); sb_push("w_after_dec", 1);
    sb_pop(w_eso); sb_pop(w_dec);

    if (sb_q.size() != 0) check_val("sb_leftover", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
